font_rom_arbiter: RTL and testbench

Shares the single synchronous font ROM between two requesters: the real-time VGA renderer fetch path (port A, absolute priority) and a background client (port B, e.g. a glyph cache or line-buffer loader) that only uses cycles the renderer leaves free. It sits between the renderer and the ROM instance and owns `rom_addr`. A tag delay line routes each returning `rom_q` word to the port that issued the read.

---
 rtl/font_rom_arbiter_pkg.sv | 14 +
 rtl/rom_tag_pipe.sv | 32 +++
 rtl/font_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_font_rom_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/font_rom_arbiter_pkg.sv
// Shared font ROM types and default geometry.
// Used by the arbiter, its tag pipe and the renderer.
package font_rom_arbiter_pkg;

   localparam int FONT_ROM_ADDR_W = 9;
   localparam int FONT_ROM_DATA_W = 4;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_A    = 2'd1,
      TAG_B    = 2'd2
   } e_rom_tag;

endpackage

// File: rtl/rom_tag_pipe.sv
// Delay line of read tags matching the ROM latency.
// Each returning rom_q word leaves with its owner tag.
module rom_tag_pipe
   import font_rom_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  e_rom_tag tag_in,
   output e_rom_tag tag_out
);

   e_rom_tag stage [DEPTH];

   // shift tags one stage per cycle; reset drops in-flight reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= TAG_NONE;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Font ROM sharing: renderer (A) has absolute priority,
// background client (B) fills the cycles A leaves free.
module font_rom_arbiter
   import font_rom_arbiter_pkg::*;
#(
   parameter int ADDR_W  = FONT_ROM_ADDR_W,
   parameter int FONT_W  = FONT_ROM_DATA_W,
   parameter int ROM_LAT = 1,
   parameter int WAIT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              rom_clk,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [FONT_W-1:0] rom_q,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_valid,
   output logic [FONT_W-1:0] a_q,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_ready,
   output logic              b_valid,
   output logic [FONT_W-1:0] b_q,
   output logic              b_starved
);

   logic              pend;
   logic [ADDR_W-1:0] pend_addr;
   logic [WAIT_W-1:0] cnt;
   e_rom_tag          iss_tag;
   e_rom_tag          tag_out;

   logic iss_a;
   logic iss_p;
   logic iss_byp;
   logic b_acc;
   logic b_latch;

   assign rom_clk = clk;

   // B can only be refused while the holding slot is full
   // and A is also taking this cycle's ROM slot
   assign b_ready = ~pend | ~a_req;
   assign b_acc   = b_req & b_ready;

   assign iss_a   = a_req;
   assign iss_p   = ~a_req & pend;
   assign iss_byp = ~a_req & ~pend & b_req;

   // accepted B that did not go straight to the ROM waits
   assign b_latch = b_acc & ~iss_byp;

   // one ROM read per edge, A first, then held B, then bypass B
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         iss_tag  <= TAG_NONE;
      end else begin
         unique case (1'b1)
            iss_a: begin
               rom_addr <= a_addr;
               iss_tag  <= TAG_A;
            end
            iss_p: begin
               rom_addr <= pend_addr;
               iss_tag  <= TAG_B;
            end
            iss_byp: begin
               rom_addr <= b_addr;
               iss_tag  <= TAG_B;
            end
            default: begin
               iss_tag  <= TAG_NONE;
            end
         endcase
      end
   end

   // one-entry B holding register; refill allowed as it drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         pend_addr <= '0;
      end else if (b_latch) begin
         pend      <= 1'b1;
         pend_addr <= b_addr;
      end else if (iss_p) begin
         pend      <= 1'b0;
      end
   end

   // count cycles the held B read is blocked, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (iss_p) begin
         cnt <= '0;
      end else if (pend & a_req & ~&cnt) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign b_starved = &cnt;

   rom_tag_pipe #(
      .DEPTH (ROM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (iss_tag),
      .tag_out (tag_out)
   );

   assign a_valid = (tag_out == TAG_A);
   assign b_valid = (tag_out == TAG_B);
   assign a_q     = rom_q;
   assign b_q     = rom_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 copies
// driven in parallel and checked against a cycle model.
module tb_font_rom_arbiter;

   localparam int WW = 3;
   localparam int SAT = (1 << WW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic a_req;
   logic b_req;
   logic [8:0] a_addr;
   logic [8:0] b_addr;

   always #5 clk = ~clk;

   logic       rom_clk1, rom_clk3;
   logic [8:0] rom_addr1, rom_addr3;
   logic [3:0] rom_q1, rom_q3;
   logic       a_valid1, a_valid3;
   logic [3:0] a_q1, a_q3;
   logic       b_ready1, b_ready3;
   logic       b_valid1, b_valid3;
   logic [3:0] b_q1, b_q3;
   logic       b_starved1, b_starved3;

   font_rom_arbiter #(
      .ADDR_W(9), .FONT_W(4), .ROM_LAT(1), .WAIT_W(WW)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rom_clk(rom_clk1),
      .rom_addr(rom_addr1), .rom_q(rom_q1),
      .a_req(a_req), .a_addr(a_addr),
      .a_valid(a_valid1), .a_q(a_q1),
      .b_req(b_req), .b_addr(b_addr), .b_ready(b_ready1),
      .b_valid(b_valid1), .b_q(b_q1), .b_starved(b_starved1)
   );

   font_rom_arbiter #(
      .ADDR_W(9), .FONT_W(4), .ROM_LAT(3), .WAIT_W(WW)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n), .rom_clk(rom_clk3),
      .rom_addr(rom_addr3), .rom_q(rom_q3),
      .a_req(a_req), .a_addr(a_addr),
      .a_valid(a_valid3), .a_q(a_q3),
      .b_req(b_req), .b_addr(b_addr), .b_ready(b_ready3),
      .b_valid(b_valid3), .b_q(b_q3), .b_starved(b_starved3)
   );

   function automatic logic [3:0] rom_val(input logic [8:0] a);
      int v;
      v = int'(a) * 5 + int'(a >> 4) * 3 + 1;
      return v[3:0];
   endfunction

   // synchronous ROMs with 1 and 3 cycles of latency
   logic [3:0] q1;
   logic [3:0] q3 [3];
   always @(posedge clk) q1 <= rom_val(rom_addr1);
   always @(posedge clk) begin
      q3[0] <= rom_val(rom_addr3);
      q3[1] <= q3[0];
      q3[2] <= q3[1];
   end
   assign rom_q1 = q1;
   assign rom_q3 = q3[2];

   // reference model state
   int         lat [2] = '{1, 3};
   int         cyc;
   bit         m_pend;
   logic [8:0] m_paddr;
   int         m_wait;
   logic [8:0] m_last;
   int         due_tag [2][64];
   logic [8:0] due_addr [2][64];

   // expected / observed bundles per copy: {ready, av, bv, st}
   logic [3:0] exp_f [2];
   logic [3:0] obs_f [2];
   logic [3:0] exp_d [2];
   logic [3:0] obs_d [2];
   logic [8:0] obs_a [2];
   logic [8:0] exp_addr;
   logic       smp_rdy [2];
   bit         exp_rdy;

   int vectors = 0;
   int miscompares = 0;

   // advance one clock edge: run the model and gather outputs
   task automatic tick();
      int itag;
      logic [8:0] iaddr;
      logic av [2];
      logic bv [2];
      logic st [2];
      logic [3:0] aq [2];
      logic [3:0] bq [2];
      itag = 0;
      iaddr = '0;
      @(negedge clk);
      smp_rdy[0] = b_ready1;
      smp_rdy[1] = b_ready3;
      if (!rst_n) begin
         m_pend = 0;
         m_wait = 0;
         m_last = '0;
         exp_rdy = 1;
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) due_tag[d][i] = 0;
      end else begin
         exp_rdy = !m_pend || !a_req;
         if (a_req) begin
            itag = 1;
            iaddr = a_addr;
            if (m_pend) begin
               if (m_wait < SAT) m_wait++;
            end else if (b_req) begin
               m_pend = 1;
               m_paddr = b_addr;
            end
         end else if (m_pend) begin
            itag = 2;
            iaddr = m_paddr;
            m_wait = 0;
            m_pend = 0;
            if (b_req) begin
               m_pend = 1;
               m_paddr = b_addr;
            end
         end else if (b_req) begin
            itag = 2;
            iaddr = b_addr;
         end
         if (itag != 0) m_last = iaddr;
      end
      @(posedge clk);
      cyc++;
      if (itag != 0) begin
         for (int d = 0; d < 2; d++) begin
            due_tag[d][(cyc + lat[d]) % 64] = itag;
            due_addr[d][(cyc + lat[d]) % 64] = iaddr;
         end
      end
      #1;
      av = '{a_valid1, a_valid3};
      bv = '{b_valid1, b_valid3};
      st = '{b_starved1, b_starved3};
      aq = '{a_q1, a_q3};
      bq = '{b_q1, b_q3};
      obs_a = '{rom_addr1, rom_addr3};
      exp_addr = m_last;
      for (int d = 0; d < 2; d++) begin
         int t;
         t = due_tag[d][cyc % 64];
         exp_f[d] = {exp_rdy, t == 1, t == 2, m_wait == SAT};
         exp_d[d] = (t != 0) ? rom_val(due_addr[d][cyc % 64]) : 4'h0;
         due_tag[d][cyc % 64] = 0;
         obs_f[d] = {smp_rdy[d], av[d], bv[d], st[d]};
         obs_d[d] = av[d] ? aq[d] : (bv[d] ? bq[d] : 4'h0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      a_req = 1'b1;
      b_req = 1'b0;
      a_addr = 9'h005;
      b_addr = 9'h000;
      #1 rst_n = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin
            a_req = 1'b0;
            rst_n = 1'b1;
         end
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr || exp_addr !== 9'h000) begin
               miscompares++;
               $display("FAIL reset dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=000",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d]);
            end
         end
      end
      vectors++;
      if (rom_clk1 !== clk || rom_clk3 !== clk) begin
         miscompares++;
         $display("FAIL rom_clk: got %b/%b want %b", rom_clk1, rom_clk3, clk);
      end
   endtask

   task automatic test_a_stream();
      for (int c = 0; c < 12; c++) begin
         a_req = (c < 8);
         a_addr = 9'(c);
         b_req = 1'b0;
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL a_stream dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int c = 0; c < 10; c++) begin
         a_req = (c < 3);
         a_addr = 9'(9'h100 + c);
         b_req = (c == 0);
         b_addr = 9'h040;
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL simultaneous dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
   endtask

   task automatic test_bypass_burst();
      for (int c = 0; c < 9; c++) begin
         a_req = (c == 4);
         a_addr = 9'h055;
         b_req = (c < 4);
         b_addr = 9'(9'h010 + c);
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL bypass dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
   endtask

   task automatic test_starvation();
      int seen;
      seen = 0;
      for (int c = 0; c < 16; c++) begin
         a_req = (c < 10);
         a_addr = 9'($urandom_range(0, 511));
         b_req = (c == 0);
         b_addr = 9'h077;
         tick();
         if (exp_f[0][0]) seen++;
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL starvation dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
      vectors++;
      if (seen != 3) begin
         miscompares++;
         $display("FAIL starvation_model cycles starved %0d want 3", seen);
      end
   endtask

   task automatic test_alternating();
      for (int c = 0; c < 24; c++) begin
         a_req = (c < 20) && (c % 2 == 0);
         a_addr = 9'($urandom_range(0, 511));
         b_req = (c < 20);
         b_addr = 9'($urandom_range(0, 511));
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr || obs_f[d][2:1] == 2'b11) begin
               miscompares++;
               $display("FAIL alternating dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 14; c++) begin
         a_req = (c < 3) || (c == 7);
         a_addr = 9'($urandom_range(0, 511));
         b_req = (c < 2) || (c == 7);
         b_addr = 9'($urandom_range(0, 511));
         if (c == 3) #3 rst_n = 1'b0;
         if (c == 5) rst_n = 1'b1;
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL reset_mid dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         a_req = ($urandom_range(0, 9) < 5);
         a_addr = 9'($urandom_range(0, 511));
         b_req = $urandom_range(0, 1) == 1;
         b_addr = 9'($urandom_range(0, 511));
         tick();
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_f[d] !== exp_f[d] || obs_d[d] !== exp_d[d]
                || obs_a[d] !== exp_addr) begin
               miscompares++;
               $display("FAIL random dut%0d cyc%0d: f=%b q=%h addr=%h want f=%b q=%h addr=%h",
                        d, cyc, obs_f[d], obs_d[d], obs_a[d], exp_f[d], exp_d[d], exp_addr);
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      cyc = 0;
      test_reset();
      test_a_stream();
      test_simultaneous();
      test_bypass_burst();
      test_starvation();
      test_alternating();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
